trng_uart_tx: RTL

Parametrised buffered UART transmitter that replaces the fixed 8N1 serial transmitter behind the TRNG output path. It accepts words through a FIFO and serialises them LSB first. Frame format, divisor and flow control are all configurable: runtime bit-period divisor, word width, parity mode, 1 or 2 stop bits, and RTS gating between frames. It sits between the TRNG framing/packet layer and the board serial pin.

---
 rtl/trng_uart_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/trng_uart_tx.sv
// trng_uart_tx: FIFO-buffered UART transmitter, LSB first, runtime divisor/parity/stop/RTS.
// Define TRNG_UART_TX_PARITY_EN to build the parity state and honour i_parity_mode.
module trng_uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [DIV_WIDTH-1:0]        i_cycles_per_bit,
  input  logic [1:0]                  i_parity_mode,
  input  logic                        i_two_stop,
  input  logic                        i_serial_rts_n,
  input  logic [DATA_BITS-1:0]        i_dat,
  input  logic                        i_write,
  output logic                        o_ready,
  output logic                        o_serial_data,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level_q, level_d;
  logic                 push, pop, load, start_ok, bit_done;
  logic [DATA_BITS-1:0] head;
  logic [DIV_WIDTH-1:0] div_clamp;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 two_stop_q, two_stop_d;
  logic                 line_d, busy_d;
`ifdef TRNG_UART_TX_PARITY_EN
  logic                 par_en_q, par_en_d, par_bit_q, par_bit_d;
`else
  logic                 unused_parity_mode;
  assign unused_parity_mode = ^i_parity_mode;
`endif

  assign o_ready   = level_q != LW'(FIFO_DEPTH);
  assign o_level   = level_q;
  assign push      = i_write && o_ready;
  assign head      = mem[rd_ptr];
  assign start_ok  = (level_q != '0) && !i_serial_rts_n;
  assign bit_done  = cnt_q == (div_q - DIV_WIDTH'(1));
  assign div_clamp = (i_cycles_per_bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_cycles_per_bit;

  // FIFO storage is not reset; occupancy is tracked by level_q.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      o_overflow <= i_write && !o_ready;
    end
  end

  // Next-state, FIFO pop and next line value; the line register mirrors state_d.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    div_d      = div_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    two_stop_d = two_stop_q;
`ifdef TRNG_UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    load       = 1'b0;
    if (state_q != IDLE) cnt_d = bit_done ? '0 : cnt_q + DIV_WIDTH'(1);

    case (state_q)
      IDLE:   load = start_ok;
      START:  if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef TRNG_UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: if (bit_done) state_d = STOP;
      STOP: begin
        if (bit_done) begin
          if (two_stop_q && (idx_q == '0)) idx_d = IW'(1);
          else if (start_ok)               load  = 1'b1;
          else                             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = START;
      cnt_d      = '0;
      idx_d      = '0;
      div_d      = div_clamp;
      shreg_d    = head;
      two_stop_d = i_two_stop;
`ifdef TRNG_UART_TX_PARITY_EN
      par_en_d   = ^i_parity_mode;
      par_bit_d  = i_parity_mode[1] ? ~^head : ^head;
`endif
    end
    pop = load;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shreg_d[0];
`ifdef TRNG_UART_TX_PARITY_EN
      PARITY:  line_d = par_bit_d;
`endif
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= DIV_WIDTH'(2);
      idx_q         <= '0;
      shreg_q       <= '0;
      two_stop_q    <= 1'b0;
      level_q       <= '0;
      o_serial_data <= 1'b1;
      o_busy        <= 1'b0;
`ifdef TRNG_UART_TX_PARITY_EN
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      two_stop_q    <= two_stop_d;
      level_q       <= level_d;
      o_serial_data <= line_d;
      o_busy        <= busy_d;
`ifdef TRNG_UART_TX_PARITY_EN
      par_en_q      <= par_en_d;
      par_bit_q     <= par_bit_d;
`endif
    end
  end
endmodule
